// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit bus CPU: steps T0..T4 and decodes the
// opcode into datapath bus-enable and step strobes, gated off by reset and halt.
module control_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_opcode,
    input  logic       i_carry_flag,
    input  logic       i_zero_flag,
    output logic       o_pc_oe,
    output logic       o_pc_step,
    output logic       o_pc_ie,
    output logic       o_mar_ie,
    output logic       o_ram_oe,
    output logic       o_ram_ie,
    output logic       o_ir_ie,
    output logic       o_ir_oe,
    output logic       o_a_ie,
    output logic       o_a_oe,
    output logic       o_b_ie,
    output logic       o_alu_oe,
    output logic       o_alu_sub,
    output logic       o_flags_ie,
    output logic       o_out_ie,
    output logic       o_halt,
    output logic [2:0] o_t_state
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } t_state_e;

    t_state_e r_t_state;
    t_state_e w_t_next;
    t_state_e w_t_adv;
    logic     r_halted;
    logic     w_halted_next;
    logic     w_last;
    logic     w_hlt;
    logic     w_en;

    logic w_pc_oe, w_pc_step, w_pc_ie, w_mar_ie, w_ram_oe, w_ram_ie, w_ir_ie, w_ir_oe;
    logic w_a_ie, w_a_oe, w_b_ie, w_alu_oe, w_alu_sub, w_flags_ie, w_out_ie;

    // T-state counter and halted flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t_state <= T0;
            r_halted  <= 1'b0;
        end else begin
            r_t_state <= w_t_next;
            r_halted  <= w_halted_next;
        end
    end

    // Microcode decode of (t_state, opcode, flags) and next-state selection
    always_comb begin
        w_pc_oe    = 1'b0;
        w_pc_step  = 1'b0;
        w_pc_ie    = 1'b0;
        w_mar_ie   = 1'b0;
        w_ram_oe   = 1'b0;
        w_ram_ie   = 1'b0;
        w_ir_ie    = 1'b0;
        w_ir_oe    = 1'b0;
        w_a_ie     = 1'b0;
        w_a_oe     = 1'b0;
        w_b_ie     = 1'b0;
        w_alu_oe   = 1'b0;
        w_alu_sub  = 1'b0;
        w_flags_ie = 1'b0;
        w_out_ie   = 1'b0;
        w_last     = 1'b0;
        w_hlt      = 1'b0;
        w_t_adv    = T0;

        case (r_t_state)
            T0: begin
                w_pc_oe  = 1'b1;
                w_mar_ie = 1'b1;
                w_t_adv  = T1;
            end
            T1: begin
                w_ram_oe  = 1'b1;
                w_ir_ie   = 1'b1;
                w_pc_step = 1'b1;
                w_t_adv   = T2;
            end
            T2: begin
                w_t_adv = T3;
                case (i_opcode)
                    4'b0001, 4'b0010, 4'b0011, 4'b0100: begin
                        w_ir_oe  = 1'b1;
                        w_mar_ie = 1'b1;
                    end
                    4'b0101: begin
                        w_ir_oe = 1'b1;
                        w_a_ie  = 1'b1;
                        w_last  = 1'b1;
                    end
                    4'b0110: begin
                        w_ir_oe = 1'b1;
                        w_pc_ie = 1'b1;
                        w_last  = 1'b1;
                    end
                    // Conditional jumps: the flag only matters here, in T2
                    4'b0111: begin
                        w_ir_oe = i_carry_flag;
                        w_pc_ie = i_carry_flag;
                        w_last  = 1'b1;
                    end
                    4'b1000: begin
                        w_ir_oe = i_zero_flag;
                        w_pc_ie = i_zero_flag;
                        w_last  = 1'b1;
                    end
                    4'b1110: begin
                        w_a_oe   = 1'b1;
                        w_out_ie = 1'b1;
                        w_last   = 1'b1;
                    end
                    4'b1111: begin
                        w_hlt = 1'b1;
                    end
                    default: begin
                        w_last = 1'b1;
                    end
                endcase
            end
            T3: begin
                w_t_adv = T4;
                case (i_opcode)
                    4'b0001: begin
                        w_ram_oe = 1'b1;
                        w_a_ie   = 1'b1;
                        w_last   = 1'b1;
                    end
                    4'b0010, 4'b0011: begin
                        w_ram_oe = 1'b1;
                        w_b_ie   = 1'b1;
                    end
                    4'b0100: begin
                        w_a_oe   = 1'b1;
                        w_ram_ie = 1'b1;
                        w_last   = 1'b1;
                    end
                    default: begin
                        w_last = 1'b1;
                    end
                endcase
            end
            T4: begin
                w_alu_oe   = 1'b1;
                w_a_ie     = 1'b1;
                w_flags_ie = 1'b1;
                w_alu_sub  = (i_opcode == 4'b0011);
                w_last     = 1'b1;
            end
            default: begin
                w_last = 1'b1;
            end
        endcase

        if (r_halted) begin
            w_t_next      = r_t_state;
            w_halted_next = 1'b1;
        end else if (w_hlt) begin
            w_t_next      = T2;
            w_halted_next = 1'b1;
        end else if (w_last) begin
            w_t_next      = T0;
            w_halted_next = 1'b0;
        end else begin
            w_t_next      = w_t_adv;
            w_halted_next = 1'b0;
        end
    end

    // Reset is a direct combinational gate so strobes drop without a clock
    assign w_en = rst_n & ~r_halted;

    assign o_pc_oe    = w_pc_oe    & w_en;
    assign o_pc_step  = w_pc_step  & w_en;
    assign o_pc_ie    = w_pc_ie    & w_en;
    assign o_mar_ie   = w_mar_ie   & w_en;
    assign o_ram_oe   = w_ram_oe   & w_en;
    assign o_ram_ie   = w_ram_ie   & w_en;
    assign o_ir_ie    = w_ir_ie    & w_en;
    assign o_ir_oe    = w_ir_oe    & w_en;
    assign o_a_ie     = w_a_ie     & w_en;
    assign o_a_oe     = w_a_oe     & w_en;
    assign o_b_ie     = w_b_ie     & w_en;
    assign o_alu_oe   = w_alu_oe   & w_en;
    assign o_alu_sub  = w_alu_sub  & w_en;
    assign o_flags_ie = w_flags_ie & w_en;
    assign o_out_ie   = w_out_ie   & w_en;
    assign o_halt     = r_halted;
    assign o_t_state  = r_t_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against a microprogram
// table model built per instruction from the opcode map.
module tb_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_opcode;
    logic       i_carry_flag;
    logic       i_zero_flag;
    logic o_pc_oe, o_pc_step, o_pc_ie, o_mar_ie, o_ram_oe, o_ram_ie, o_ir_ie, o_ir_oe;
    logic o_a_ie, o_a_oe, o_b_ie, o_alu_oe, o_alu_sub, o_flags_ie, o_out_ie, o_halt;
    logic [2:0] o_t_state;

    int n_tests;
    int n_fail;

    localparam logic [14:0] PC_OE    = 15'd1 << 0;
    localparam logic [14:0] PC_STEP  = 15'd1 << 1;
    localparam logic [14:0] PC_IE    = 15'd1 << 2;
    localparam logic [14:0] MAR_IE   = 15'd1 << 3;
    localparam logic [14:0] RAM_OE   = 15'd1 << 4;
    localparam logic [14:0] RAM_IE   = 15'd1 << 5;
    localparam logic [14:0] IR_IE    = 15'd1 << 6;
    localparam logic [14:0] IR_OE    = 15'd1 << 7;
    localparam logic [14:0] A_IE     = 15'd1 << 8;
    localparam logic [14:0] A_OE     = 15'd1 << 9;
    localparam logic [14:0] B_IE     = 15'd1 << 10;
    localparam logic [14:0] ALU_OE   = 15'd1 << 11;
    localparam logic [14:0] ALU_SUB  = 15'd1 << 12;
    localparam logic [14:0] FLAGS_IE = 15'd1 << 13;
    localparam logic [14:0] OUT_IE   = 15'd1 << 14;

    logic [14:0] prog_q[$];
    logic [14:0] w_obs;

    assign w_obs = {o_out_ie, o_flags_ie, o_alu_sub, o_alu_oe, o_b_ie, o_a_oe, o_a_ie,
                    o_ir_oe, o_ir_ie, o_ram_ie, o_ram_oe, o_mar_ie, o_pc_ie, o_pc_step, o_pc_oe};

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_opcode(i_opcode),
        .i_carry_flag(i_carry_flag), .i_zero_flag(i_zero_flag),
        .o_pc_oe(o_pc_oe), .o_pc_step(o_pc_step), .o_pc_ie(o_pc_ie), .o_mar_ie(o_mar_ie),
        .o_ram_oe(o_ram_oe), .o_ram_ie(o_ram_ie), .o_ir_ie(o_ir_ie), .o_ir_oe(o_ir_oe),
        .o_a_ie(o_a_ie), .o_a_oe(o_a_oe), .o_b_ie(o_b_ie), .o_alu_oe(o_alu_oe),
        .o_alu_sub(o_alu_sub), .o_flags_ie(o_flags_ie), .o_out_ie(o_out_ie),
        .o_halt(o_halt), .o_t_state(o_t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected microprogram of one instruction, one strobe word per cycle
    task automatic build_prog(input logic [3:0] op, input logic c, input logic z);
        prog_q = {};
        prog_q.push_back(PC_OE | MAR_IE);
        prog_q.push_back(RAM_OE | IR_IE | PC_STEP);
        case (op)
            4'd1:  begin prog_q.push_back(IR_OE | MAR_IE); prog_q.push_back(RAM_OE | A_IE); end
            4'd2:  begin prog_q.push_back(IR_OE | MAR_IE); prog_q.push_back(RAM_OE | B_IE);
                         prog_q.push_back(ALU_OE | A_IE | FLAGS_IE); end
            4'd3:  begin prog_q.push_back(IR_OE | MAR_IE); prog_q.push_back(RAM_OE | B_IE);
                         prog_q.push_back(ALU_OE | A_IE | FLAGS_IE | ALU_SUB); end
            4'd4:  begin prog_q.push_back(IR_OE | MAR_IE); prog_q.push_back(A_OE | RAM_IE); end
            4'd5:  prog_q.push_back(IR_OE | A_IE);
            4'd6:  prog_q.push_back(IR_OE | PC_IE);
            4'd7:  prog_q.push_back(c ? (IR_OE | PC_IE) : 15'd0);
            4'd8:  prog_q.push_back(z ? (IR_OE | PC_IE) : 15'd0);
            4'd14: prog_q.push_back(A_OE | OUT_IE);
            default: prog_q.push_back(15'd0);
        endcase
    endtask

    // Runs one instruction from T0; entered and left at posedge+1.
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z, input int abort_k);
        int len;
        logic [14:0] bus;
        build_prog(op, c, z);
        len = prog_q.size();
        for (int k = 0; k < len; k++) begin
            i_opcode     = (k < 2) ? 4'($urandom_range(15, 0)) : op;
            i_carry_flag = (k == 2) ? c : 1'($urandom_range(1, 0));
            i_zero_flag  = (k == 2) ? z : 1'($urandom_range(1, 0));
            @(negedge clk);
            check("t_state", 32'(o_t_state), k);
            check("strobes", 32'(w_obs), 32'(prog_q[k]));
            check("halt_low", 32'(o_halt), 0);
            bus = w_obs & (PC_OE | RAM_OE | IR_OE | A_OE | ALU_OE);
            check("bus_excl", 32'($countones(bus) <= 1), 1);
            check("pc_step_ie", 32'(o_pc_step & o_pc_ie), 0);
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                #1;
                check("arst_strobes", 32'(w_obs), 0);
                check("arst_t_state", 32'(o_t_state), 0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        // Length check: next cycle must be T0 again
        check("len_ret_t0", 32'(o_t_state), 0);
    endtask

    initial begin
        logic [3:0] op;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        i_opcode = 4'd0;
        i_carry_flag = 1'b0;
        i_zero_flag = 1'b0;
        #3;
        check("rst_strobes", 32'(w_obs), 0);
        check("rst_t_state", 32'(o_t_state), 0);
        check("rst_halt", 32'(o_halt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr(4'd0, 1'b0, 1'b0, -1);
        run_instr(4'd2, 1'b1, 1'b0, -1);
        run_instr(4'd3, 1'b0, 1'b1, -1);
        run_instr(4'd7, 1'b1, 1'b0, -1);
        run_instr(4'd7, 1'b0, 1'b1, -1);
        run_instr(4'd8, 1'b0, 1'b1, -1);
        run_instr(4'd8, 1'b1, 1'b0, -1);
        run_instr(4'd1, 1'b0, 1'b0, -1);
        run_instr(4'd4, 1'b0, 1'b0, -1);
        run_instr(4'd5, 1'b0, 1'b0, -1);
        run_instr(4'd6, 1'b0, 1'b0, -1);
        run_instr(4'd14, 1'b0, 1'b0, -1);
        run_instr(4'd10, 1'b0, 1'b0, -1);

        // HLT: T0..T2 then frozen with t_state=2
        build_prog(4'd15, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            i_opcode = (k < 2) ? 4'($urandom_range(15, 0)) : 4'd15;
            @(negedge clk);
            check("hlt_t_state", 32'(o_t_state), k);
            check("hlt_strobes", 32'(w_obs), 32'(prog_q[k]));
            @(posedge clk);
            #1;
        end
        for (int n = 0; n < 10; n++) begin
            i_carry_flag = 1'($urandom_range(1, 0));
            i_zero_flag  = 1'($urandom_range(1, 0));
            @(negedge clk);
            check("halted_flag", 32'(o_halt), 1);
            check("halted_t_state", 32'(o_t_state), 2);
            check("halted_strobes", 32'(w_obs), 0);
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        check("unhalt_halt", 32'(o_halt), 0);
        check("unhalt_t_state", 32'(o_t_state), 0);
        check("unhalt_strobes", 32'(w_obs), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_instr(4'd0, 1'b0, 1'b0, -1);

        // Asynchronous reset in T3 of LDA, then normal operation resumes
        run_instr(4'd1, 1'b0, 1'b0, 3);
        run_instr(4'd2, 1'b0, 1'b0, -1);

        for (int i = 0; i < 1000; i++) begin
            op = 4'($urandom_range(14, 0));
            run_instr(op, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the 8-bit bus CPU. It steps a T-state counter and decodes the 4-bit opcode from the instruction register. From these it drives every bus-enable and step strobe in the datapath, including ie/oe/step of the program counter. It sits directly upstream of the program counter, MAR, RAM, instruction register, A/B registers, ALU and output register.

## Interface
Parameters: none (opcode map and microcode are fixed).
- clk  input  1  system clock; sequencer state changes on posedge, datapath registers act on negedge
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  4  upper nibble of instruction register, valid from T2 onward
- carry_flag  input  1  registered ALU carry
- zero_flag  input  1  registered ALU zero
- pc_oe, pc_step, pc_ie  output  1 each  program counter bus-out / increment / load
- mar_ie  output  1  memory address register load
- ram_oe, ram_ie  output  1 each  RAM read to bus / write from bus
- ir_ie, ir_oe  output  1 each  instruction register load / operand (low nibble) to bus
- a_ie, a_oe, b_ie  output  1 each  A register load / out, B register load
- alu_oe, alu_sub, flags_ie  output  1 each  ALU result to bus, subtract select, flag register load
- out_ie  output  1  output register load
- halt  output  1  CPU stopped
- t_state  output  3  current T-state (0–4), debug

## Operation
- State: t_state register 0..4 plus halted flag. Control outputs are combinational decode of (t_state, opcode, flags), gated by !halted.
- Fetch, all opcodes:
  - T0: pc_oe, mar_ie
  - T1: ram_oe, ir_ie, pc_step
- Execute (T2..), opcode map:
  - 0000 NOP: T2 no strobes
  - 0001 LDA: T2 ir_oe+mar_ie; T3 ram_oe+a_ie
  - 0010 ADD: T2 ir_oe+mar_ie; T3 ram_oe+b_ie; T4 alu_oe+a_ie+flags_ie
  - 0011 SUB: as ADD, with alu_sub asserted in T4
  - 0100 STA: T2 ir_oe+mar_ie; T3 a_oe+ram_ie
  - 0101 LDI: T2 ir_oe+a_ie
  - 0110 JMP: T2 ir_oe+pc_ie
  - 0111 JC: T2 ir_oe+pc_ie if carry_flag=1, else no strobes
  - 1000 JZ: as JC using zero_flag
  - 1110 OUT: T2 a_oe+out_ie
  - 1111 HLT: T2 sets halted
  - 1001–1101: undefined, behave as NOP
- Variable length: the step listed last for an opcode is final, and the next posedge returns t_state to 0. Cycle counts:
  - 3 cycles: NOP, undefined, LDI, JMP, OUT, not-taken JC/JZ
  - 4 cycles: LDA, STA
  - 5 cycles: ADD, SUB
- Flags are sampled only during T2 of JC/JZ; changes at other times have no effect.
- Bus exclusivity invariant: at most one of pc_oe, ram_oe, ir_oe, a_oe, alu_oe is high in any cycle.
- pc_step and pc_ie are never high together.

## Timing
- Reset (rst_n=0): t_state=0, halted=0, every control output forced 0 immediately (combinational gate on rst_n), halt=0.
- First posedge after rst_n rises: no state change required. T0 decode is visible as soon as rst_n is high, so the first negedge performs the T0 transfer.
- Each posedge: t_state advances by 1, or returns to 0 after a final step.
- Outputs settle within the posedge-to-negedge half-cycle; consumers (PC etc.) sample on negedge.
- HLT:
  - halted is set on the posedge ending T2.
  - From then: t_state holds 2, all control outputs are 0, halt=1.
  - Only rst_n clears it.
- Reset mid-instruction: asynchronous return to T0 and outputs 0 in any state, including halted.
- opcode changing during T0/T1 is ignored. opcode is not latched internally, so the IR must hold it stable T2..end.

## Test plan
- Reset then 3 clocks with opcode=0000:
  - pre-release: all outputs 0, t_state=0
  - then T0 pc_oe=mar_ie=1; T1 ram_oe=ir_ie=pc_step=1; T2 nothing
  - back to t_state=0 on the 4th posedge
- opcode=0010 (ADD) and 0011 (SUB):
  - exactly 5 cycles with the listed strobes
  - alu_sub=1 only in T4 for SUB, 0 throughout ADD
  - flags_ie high only in T4
- opcode=0111 (JC):
  - carry_flag=1: pc_ie=ir_oe=1 in T2
  - carry_flag=0: no strobes in T2
  - both cases return to T0 after 3 cycles
  - repeat for JZ with zero_flag
- opcode=1111 (HLT):
  - halt=1 after T2 posedge
  - 10 further clocks: t_state=2, all strobes 0
  - pulse rst_n low: halt=0, t_state=0, T0 decode on release
- Assert rst_n low asynchronously (between edges) during T3 of LDA: outputs drop to 0 without a clock, t_state=0.
- Random opcode stream, 1000 instructions: checker confirms the bus-exclusivity invariant, pc_step/pc_ie never both high, and per-opcode cycle count.
